// File: rtl/otter_intc.sv
`default_nettype none
// ============================================================================
// Module   : otter_intc
// Desc     : Multi-source interrupt controller for the OTTER MCU. Define
//            OTTER_INTC_SYNC_EN to add a 2-flop synchronizer per source.
// Revision : 1.0 - initial release
// ============================================================================

module otter_intc #(
    parameter int NSRC = 8,
    parameter int CW   = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            RST_n,
    input  logic [NSRC-1:0] src,
    input  logic            mie,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            int_taken,
    input  logic            mret_exec,
    output logic            intr,
    output logic [CW-1:0]   cause,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cause;
    logic [CW-1:0]   w_cause_nxt;
    logic [CW-1:0]   w_pick;
    logic [NSRC-1:0] r_sync;
    logic [NSRC-1:0] r_prev;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_clr;

`ifdef OTTER_INTC_SYNC_EN
    localparam int c_NSTG = 2;
    logic [NSRC-1:0] r_meta;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= src;
            r_sync <= r_meta;
        end
    end
`else
    localparam int c_NSTG = 1;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= src;
        end
    end
`endif

    // Edges count only once r_prev holds a post-reset sample, so a line that
    // is already high when reset releases is treated as a level, not an edge.
    logic [c_NSTG:0] r_vld;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_prev <= '0;
            r_vld  <= '0;
        end else begin
            r_prev <= r_sync;
            r_vld  <= {r_vld[c_NSTG-1:0], 1'b1};
        end
    end

    assign w_edge = r_vld[c_NSTG] ? (r_sync & ~r_prev) : '0;
    assign w_elig = r_pending & r_mask;

    always_comb begin
        w_pick = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_pick = CW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (mie && (|w_elig)) begin
                    w_state_nxt = ST_REQ;
                    w_cause_nxt = w_pick;
                end
            end
            ST_REQ: begin
                if (int_taken) begin
                    w_clr[r_cause] = 1'b1;
                    w_state_nxt    = ST_SERVICE;
                end else if (!mie || !w_elig[r_cause]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (mret_exec) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= ST_IDLE;
            r_cause   <= '0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            // A new edge on a bit being cleared keeps it pending
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign intr    = (r_state == ST_REQ);
    assign busy    = (r_state == ST_SERVICE);
    assign cause   = r_cause;
    assign pending = r_pending;
    assign mask    = r_mask;

endmodule

`default_nettype wire

// File: doc/otter_intc.md
# otter_intc

Multi-source interrupt controller for the OTTER RISC-V MCU. It synchronizes up to `NSRC` external interrupt lines, latches rising edges into a pending register, and applies a per-source mask and the global `mie` enable. It selects the highest-priority source and drives the single `intr` input of the control-unit FSM, completing the handshake on the FSM's `int_taken` and on `mret`. It sits between the board-level peripherals and the control unit/CSR file, and exposes a latched `cause` index for the trap handler.

## Interface
- `NSRC`, default 8, number of interrupt sources (2..16); index 0 has the highest priority.
- `CW`, default `$clog2(NSRC)`, width of `cause`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `RST_n`  in  1  reset, asynchronous, active-low.
- `src`  in  NSRC  raw interrupt lines, asynchronous to `clk`, rising-edge sensitive.
- `mie`  in  1  global interrupt enable from the CSR file.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  NSRC  new mask value; bit=1 enables the source.
- `int_taken`  in  1  one-cycle pulse from the control unit's INTERRUPT state.
- `mret_exec`  in  1  one-cycle pulse when `mret` executes.
- `intr`  out  1  interrupt request to the control unit.
- `cause`  out  CW  index of the source being requested or serviced.
- `pending`  out  NSRC  pending-bit register, readable by software.
- `mask`  out  NSRC  current mask register.
- `busy`  out  1  high while in SERVICE.

## Operation
- Reset (`RST_n`=0, immediate): state=IDLE, `intr`=0, `cause`=0, `pending`=0, `mask`=all ones, `busy`=0, all synchronizer and edge flops=0. Reset asserted mid-operation discards every pending and in-service interrupt.
- Edge detect: `edge[i] = s[i] & ~prev[i]`, where `s` is the synchronized `src` and `prev <= s` every cycle. `edge[i]` sets `pending[i]`. A level held high produces exactly one pending event.
- Eligible vector: `elig = pending & mask`, with a request possible only when `mie`=1.
- FSM:
  - IDLE: `intr`=0. If `mie` and `|elig`, latch `cause` = the lowest set index of `elig` and go to REQ.
  - REQ: `intr`=1 and `cause` is frozen.
    - On `int_taken`, clear `pending[cause]` and go to SERVICE.
    - Otherwise, if `mie`=0 or `elig[cause]`=0 (masked meanwhile), go to IDLE with `pending` untouched.
  - SERVICE: `intr`=0, `busy`=1, `cause` held. On `mret_exec`, go to IDLE. `int_taken` in this state is ignored.
  - Illegal state encoding: go to IDLE.
- There is no nesting. New edges in REQ or SERVICE only set pending bits and are arbitrated on the return to IDLE.
- Simultaneous set and clear of the same bit: set wins, so the bit stays pending.
- `mask_we`: `mask <= mask_wdata` on the next edge. Masking never clears pending bits.
- Priority is fixed, with index 0 highest. No round-robin.

## Timing
- With synchronizer (see Configuration):
  - `src[i]` high before edge E1 → `s[i]`=1 after E2 → `pending[i]`=1 after E3 → `intr`=1 after E4.
  - Worst-case latency from `src` to `intr` is 4 clocks.
- `int_taken` sampled high at edge T → `pending[cause]`=0, `intr`=0 and `busy`=1 after T.
- `mret_exec` at edge M → IDLE after M. If an eligible bit is pending, `intr`=1 again after M+1.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to `intr`.

## Configuration
- `OTTER_INTC_SYNC_EN` defined: a 2-flop synchronizer sits per source ahead of the edge detector. Latency is as in Timing (4 clocks from `src` to `intr`).
- Not defined: a single sampling flop (`s <= src`). `pending` sets after E2 and `intr` asserts after E3 (3 clocks). Use this only when `src` is already synchronous to `clk`.

## Test plan
- Reset: hold `RST_n`=0 with `src`=8'hFF → `intr`=0, `pending`=0, `mask`=8'hFF. Release with `src` still 8'hFF → no pending bits set, because there is no rising edge.
- Single source: `mie`=1, pulse `src[3]` → `intr`=1 at the 4th edge with `cause`=3. `int_taken` pulse → `pending`=0, `busy`=1. `mret_exec` → IDLE and `intr` stays 0.
- Priority: raise `src[5]` and `src[2]` in the same cycle → `cause`=2 first. After `int_taken`/`mret_exec`, `intr` rises again with `cause`=5.
- Mask and `mie`: `mask`=8'hF7, pulse `src[3]` → `pending[3]`=1 and `intr`=0. Write `mask`=8'hFF → `intr`=1. In REQ, drop `mie` → `intr`=0 next cycle and `pending[3]` stays 1.
- Set-wins collision: pulse `src[1]` so its edge lands on the same cycle as `int_taken` for `cause`=1 → `pending[1]` remains 1 and is re-requested after `mret_exec`.
- Async reset mid-SERVICE: assert `RST_n`=0 between clock edges → `busy`, `intr` and `pending` go to 0 immediately, without waiting for a clock edge.
